// File: rtl/rocev2_deadlock_pkg.sv
// Shared types and default sizing for the HLS deadlock reporter.
package rocev2_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        QUALIFY      = 2'd1,
        REPORT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } dl_state_t;

    localparam int DEF_NUM_PROC    = 55;
    localparam int DEF_NUM_AXIS    = 10;
    localparam int DEF_QUAL_CYCLES = 16;
    localparam int DEF_TS_W        = 32;
    localparam int DEF_CNT_W       = 8;

    // Wide enough to hold QUAL_CYCLES itself, so 1..65535 all fit.
    function automatic int qual_cnt_width(input int qual_cycles);
        return $clog2(qual_cycles + 1);
    endfunction

    localparam int DEF_QUAL_W = qual_cnt_width(DEF_QUAL_CYCLES);

endpackage

// File: rtl/rocev2_top_hls_deadlock_tsc.sv
// Free-running timestamp counter; wraps naturally at 2^TS_W.
module rocev2_top_hls_deadlock_tsc #(
    parameter int TS_W = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [TS_W-1:0] ts
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

endmodule

// File: rtl/rocev2_top_hls_deadlock_reporter.sv
// Qualifies the monitor's block flag, snapshots the block vectors with a
// timestamp, and presents one report per deadlock episode plus a sticky IRQ.
module rocev2_top_hls_deadlock_reporter
    import rocev2_deadlock_pkg::*;
#(
    parameter int NUM_PROC    = DEF_NUM_PROC,
    parameter int NUM_AXIS    = DEF_NUM_AXIS,
    parameter int QUAL_CYCLES = DEF_QUAL_CYCLES,
    parameter int TS_W        = DEF_TS_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                block_in,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [NUM_PROC-1:0] report_proc_vec,
    output logic [NUM_AXIS-1:0] report_axis_vec,
    output logic [TS_W-1:0]     report_ts,
    output logic [CNT_W-1:0]    event_count,
    output logic                deadlock_irq,
    input  logic                irq_clear,
    output logic [1:0]          dbg_state
);

    localparam int              QW        = qual_cnt_width(QUAL_CYCLES);
    localparam logic [QW-1:0]   QUAL_LAST = QW'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    dl_state_t       state, state_nxt;
    logic [QW-1:0]   qual_cnt, qual_nxt;
    logic            capture;
    logic [TS_W-1:0] ts_now;

    rocev2_top_hls_deadlock_tsc #(
        .TS_W (TS_W)
    ) u_tsc (
        .clock   (clock),
        .reset_n (reset_n),
        .ts      (ts_now)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            qual_cnt <= '0;
        end else begin
            state    <= state_nxt;
            qual_cnt <= qual_nxt;
        end
    end

    // Report handshake: a transfer happens on an edge where report_valid and
    // report_ready are both high. report_valid is decoded from the registered
    // state only, so report_ready never reaches it combinationally.
    always_comb begin
        state_nxt = state;
        qual_nxt  = qual_cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (block_in) begin
                    if (QUAL_CYCLES == 1) begin
                        capture   = 1'b1;
                        state_nxt = REPORT;
                    end else begin
                        qual_nxt  = QW'(1);
                        state_nxt = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!block_in) begin
                    qual_nxt  = '0;
                    state_nxt = IDLE;
                end else if (qual_cnt == QUAL_LAST) begin
                    capture   = 1'b1;
                    qual_nxt  = '0;
                    state_nxt = REPORT;
                end else begin
                    qual_nxt = qual_cnt + QW'(1);
                end
            end
            REPORT: begin
                if (report_ready) begin
                    state_nxt = block_in ? WAIT_RELEASE : IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (!block_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            report_proc_vec <= '0;
            report_axis_vec <= '0;
            report_ts       <= '0;
            event_count     <= '0;
        end else if (capture) begin
            report_proc_vec <= inst_block_sigs;
            report_axis_vec <= axis_block_sigs;
            report_ts       <= ts_now;
            if (event_count != CNT_MAX) begin
                event_count <= event_count + CNT_W'(1);
            end
        end
    end

    // A capture on the same edge as irq_clear leaves the interrupt set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deadlock_irq <= 1'b0;
        end else if (capture) begin
            deadlock_irq <= 1'b1;
        end else if (irq_clear) begin
            deadlock_irq <= 1'b0;
        end
    end

    assign report_valid = (state == REPORT);
    assign dbg_state    = state;

endmodule

// File: tb/tb_rocev2_top_hls_deadlock_reporter.sv
// Bench for the deadlock reporter: two instances (QUAL_CYCLES=4 full width,
// QUAL_CYCLES=1 with narrow counters) share stimulus and an episode model.
module tb_rocev2_top_hls_deadlock_reporter;
    import rocev2_deadlock_pkg::*;

    localparam int NP = 55;
    localparam int NA = 10;
    localparam int RW = NP + NA + 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          block_in = 1'b0;
    logic          report_ready = 1'b0;
    logic          irq_clear = 1'b0;
    logic [NP-1:0] inst_block_sigs = '0;
    logic [NA-1:0] axis_block_sigs = '0;

    logic          a_valid, a_irq;
    logic [NP-1:0] a_proc;
    logic [NA-1:0] a_axis;
    logic [31:0]   a_ts;
    logic [7:0]    a_cnt;
    logic [1:0]    a_state;

    logic          b_valid, b_irq;
    logic [NP-1:0] b_proc;
    logic [NA-1:0] b_axis;
    logic [3:0]    b_ts;
    logic [1:0]    b_cnt;
    logic [1:0]    b_state;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    rocev2_top_hls_deadlock_reporter #(
        .NUM_PROC(NP), .NUM_AXIS(NA), .QUAL_CYCLES(4), .TS_W(32), .CNT_W(8)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .block_in(block_in),
        .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs),
        .report_valid(a_valid), .report_ready(report_ready),
        .report_proc_vec(a_proc), .report_axis_vec(a_axis), .report_ts(a_ts),
        .event_count(a_cnt), .deadlock_irq(a_irq), .irq_clear(irq_clear),
        .dbg_state(a_state)
    );

    rocev2_top_hls_deadlock_reporter #(
        .NUM_PROC(NP), .NUM_AXIS(NA), .QUAL_CYCLES(1), .TS_W(4), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .block_in(block_in),
        .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs),
        .report_valid(b_valid), .report_ready(report_ready),
        .report_proc_vec(b_proc), .report_axis_vec(b_axis), .report_ts(b_ts),
        .event_count(b_cnt), .deadlock_irq(b_irq), .irq_clear(irq_clear),
        .dbg_state(b_state)
    );

    // ---------------- reference model ----------------
    // Episode view: count consecutive high samples while armed; once a report
    // is outstanding nothing counts until it is taken, and if block_in was
    // still high then, the episode must end (a low sample) before re-arming.
    int          run      [2];
    bit          pending  [2];
    bit          armed    [2];
    logic [31:0] ts_cnt   [2];
    int          evcnt    [2];
    bit          irq_m    [2];
    int          qual     [2] = '{4, 1};
    logic [31:0] tsmask   [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    int          cmax     [2] = '{255, 3};
    logic [RW-1:0] exp_qa[$];
    logic [RW-1:0] exp_qb[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; pending[i] = 0; armed[i] = 1;
            ts_cnt[i] = '0; evcnt[i] = 0; irq_m[i] = 0;
        end
        exp_qa.delete();
        exp_qb.delete();
    endtask

    task automatic model_edge(input int i);
        bit cap;
        logic [RW-1:0] snap;
        cap = 0;
        if (pending[i]) begin
            if (report_ready) begin
                pending[i] = 0;
                armed[i]   = !block_in;
                if (i == 0) void'(exp_qa.pop_front());
                else        void'(exp_qb.pop_front());
            end
        end else if (!armed[i]) begin
            if (!block_in) armed[i] = 1;
        end else if (block_in) begin
            run[i] = run[i] + 1;
            if (run[i] >= qual[i]) begin
                cap = 1;
                run[i] = 0;
            end
        end else begin
            run[i] = 0;
        end
        if (cap) begin
            snap = {inst_block_sigs, axis_block_sigs, ts_cnt[i] & tsmask[i]};
            if (i == 0) exp_qa.push_back(snap);
            else        exp_qb.push_back(snap);
            pending[i] = 1;
            armed[i]   = 0;
            if (evcnt[i] < cmax[i]) evcnt[i] = evcnt[i] + 1;
            irq_m[i] = 1;
        end else if (irq_clear) begin
            irq_m[i] = 0;
        end
        ts_cnt[i] = (ts_cnt[i] + 32'd1) & tsmask[i];
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [RW-1:0] e;
        check("a_valid", 64'(a_valid), 64'(pending[0]));
        check("a_irq",   64'(a_irq),   64'(irq_m[0]));
        check("a_cnt",   64'(a_cnt),   64'(evcnt[0]));
        if (pending[0] && exp_qa.size() > 0) begin
            e = exp_qa[0];
            check("a_proc", 64'(a_proc), 64'(e[RW-1 -: NP]));
            check("a_axis", 64'(a_axis), 64'(e[32 +: NA]));
            check("a_ts",   64'(a_ts),   64'(e[31:0]));
        end
        check("b_valid", 64'(b_valid), 64'(pending[1]));
        check("b_irq",   64'(b_irq),   64'(irq_m[1]));
        check("b_cnt",   64'(b_cnt),   64'(evcnt[1]));
        if (pending[1] && exp_qb.size() > 0) begin
            e = exp_qb[0];
            check("b_proc", 64'(b_proc), 64'(e[RW-1 -: NP]));
            check("b_axis", 64'(b_axis), 64'(e[32 +: NA]));
            check("b_ts",   64'(b_ts),   64'(e[31:0]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
        check({tag, "_a_proc"},  64'(a_proc),  64'd0);
        check({tag, "_a_axis"},  64'(a_axis),  64'd0);
        check({tag, "_a_ts"},    64'(a_ts),    64'd0);
        check({tag, "_a_cnt"},   64'(a_cnt),   64'd0);
        check({tag, "_a_irq"},   64'(a_irq),   64'd0);
        check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
        check({tag, "_b_ts"},    64'(b_ts),    64'd0);
        check({tag, "_b_cnt"},   64'(b_cnt),   64'd0);
        check({tag, "_b_irq"},   64'(b_irq),   64'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic rand_vecs();
        inst_block_sigs = NP'({$urandom(), $urandom()});
        axis_block_sigs = NA'($urandom());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len;
        int guard;

        do_reset();
        check_all_zero("reset");

        // Short pulse: three high samples never qualify at QUAL_CYCLES=4.
        block_in = 1'b1;
        repeat (3) step();
        block_in = 1'b0;
        repeat (4) step();
        check("t1_valid", 64'(a_valid), 64'd0);
        check("t1_cnt",   64'(a_cnt),   64'd0);
        check("t1_irq",   64'(a_irq),   64'd0);

        // Qualified deadlock starting at timestamp 100.
        guard = 0;
        while (ts_cnt[0] != 32'd100 && guard < 300) begin
            step();
            guard++;
        end
        check("t2_reach_ts100", 64'(ts_cnt[0]), 64'd100);
        block_in = 1'b1;
        inst_block_sigs = NP'(1);
        axis_block_sigs = 10'h200;
        repeat (3) step();
        check("t2_not_yet", 64'(a_valid), 64'd0);
        step();
        check("t2_valid", 64'(a_valid), 64'd1);
        check("t2_ts",    64'(a_ts),    64'd103);
        check("t2_proc",  64'(a_proc),  64'd1);
        check("t2_axis",  64'(a_axis),  64'h200);
        check("t2_cnt",   64'(a_cnt),   64'd1);
        check("t2_irq",   64'(a_irq),   64'd1);

        // Backpressure: inputs churn while the report is held.
        for (int k = 0; k < 20; k++) begin
            rand_vecs();
            block_in = (k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        check("t3_hold_ts",   64'(a_ts),   64'd103);
        check("t3_hold_proc", 64'(a_proc), 64'd1);
        block_in = 1'b1;
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        check("t3_wait", 64'(a_state), 64'(WAIT_RELEASE));
        repeat (10) step();
        check("t3_no_second", 64'(a_valid), 64'd0);
        check("t3_cnt",       64'(a_cnt),   64'd1);
        block_in = 1'b0;
        repeat (2) step();
        block_in = 1'b1;
        rand_vecs();
        repeat (4) step();
        check("t3_requal", 64'(a_valid), 64'd1);

        // IRQ race: clear on the capture edge loses to set.
        block_in = 1'b0;
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        check("t4_cleared", 64'(a_irq), 64'd0);
        repeat (2) step();
        block_in = 1'b1;
        repeat (3) step();
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        check("t4_set_wins", 64'(a_irq),   64'd1);
        check("t4_valid",    64'(a_valid), 64'd1);
        step();
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        check("t4_clear", 64'(a_irq), 64'd0);
        report_ready = 1'b1;
        step();

        // Random episodes: saturation and timestamp wrap on the narrow instance.
        for (int n = 0; n < 800; ) begin
            len = $urandom_range(1, 8);
            block_in = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < len; j++) begin
                rand_vecs();
                report_ready = ($urandom_range(0, 3) == 0);
                irq_clear = ($urandom_range(0, 19) == 0);
                step();
                n++;
            end
        end
        irq_clear = 1'b0;
        check("t5_b_sat", 64'(b_cnt), 64'd3);

        // Reset while a report is outstanding.
        block_in = 1'b0;
        report_ready = 1'b1;
        repeat (2) step();
        report_ready = 1'b0;
        block_in = 1'b1;
        rand_vecs();
        repeat (4) step();
        check("t6_in_report", 64'(a_valid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("t6_b_first_valid", 64'(b_valid), 64'd1);
        check("t6_b_first_ts",    64'(b_ts),    64'd0);
        check("t6_b_state",       64'(b_state), 64'(REPORT));
        check("t6_b_cnt",         64'(b_cnt),   64'd1);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
